host_run_ctrl: RTL

//   Host-side sequencer for the CPU core's external load/debug port (data_in/addr_in/cmd/data_out).

---
 rtl/host_run_ctrl_pkg.sv | 27 ++
 rtl/host_run_ctrl_run_timer.sv | 39 +++
 rtl/host_run_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/host_run_ctrl_pkg.sv
// Shared definitions for the host run controller: host op encodings, FSM states, latency bounds.
package host_run_ctrl_pkg;

    typedef enum logic [1:0] {
        OpRegRd  = 2'b00,
        OpImemWr = 2'b01,
        OpDmemRd = 2'b10,
        OpDmemWr = 2'b11
    } host_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StResp,
        StRun
    } state_e;

    localparam int unsigned ReadLatMin = 0;
    localparam int unsigned ReadLatMax = 3;

    // Both write encodings have bit 0 set.
    function automatic logic op_is_write(host_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/host_run_ctrl_run_timer.sv
// RUN-cycle counter: clears on run start, counts while enabled, saturates, flags the MAX_RUN limit.
module host_run_ctrl_run_timer #(
    parameter int unsigned MAX_RUN = 0,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             halt_hit_o
);

    localparam logic [CNT_W-1:0] HaltAt = CNT_W'(MAX_RUN - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // The limit cycle still counts, so a halted run reports exactly MAX_RUN cycles.
    assign halt_hit_o = en_i && (MAX_RUN != 0) && (count_q == HaltAt);
    assign count_o    = count_q;

endmodule

// File: rtl/host_run_ctrl.sv
// Host-side sequencer for the core load/debug port: serialises host commands, returns read data,
// and owns core reset (held while halted, released while running).
module host_run_ctrl
    import host_run_ctrl_pkg::*;
#(
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned MAX_RUN  = 0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             host_valid_i,
    output logic             host_ready_o,
    input  logic [1:0]       host_op_i,
    input  logic [31:0]      host_addr_i,
    input  logic [31:0]      host_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    input  logic             run_req_i,
    input  logic             halt_req_i,
    output logic             core_reset_o,
    output logic             running_o,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [1:0]       cmd_o,
    output logic [31:0]      addr_o,
    output logic [31:0]      data_o,
    input  logic [31:0]      data_i
);

    localparam logic [1:0] ReadLatW = 2'(READ_LAT);

    state_e      state_q, state_d;
    host_op_e    op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  wait_q, wait_d;
    logic        run_start;
    logic        halt_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            op_q       <= OpRegRd;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            wait_q     <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        wait_d     = wait_q;
        run_start  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // run_req wins over a host command; run_req with halt_req is a no-op.
                if (run_req_i) begin
                    if (!halt_req_i) begin
                        state_d   = StRun;
                        run_start = 1'b1;
                    end
                end else if (host_valid_i) begin
                    op_d    = host_op_e'(host_op_i);
                    addr_d  = host_addr_i;
                    wdata_d = host_wdata_i;
                    wait_d  = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (op_is_write(op_q)) begin
                    state_d = StIdle;
                end else if (ReadLatW == 2'd0) begin
                    rsp_data_d = data_i;
                    state_d    = StResp;
                end else begin
                    wait_d  = 2'd1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (wait_q == ReadLatW) begin
                    rsp_data_d = data_i;
                    state_d    = StResp;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (halt_req_i || halt_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    host_run_ctrl_run_timer #(
        .MAX_RUN (MAX_RUN),
        .CNT_W   (CNT_W)
    ) u_run_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (run_start),
        .en_i       (state_q == StRun),
        .count_o    (cycle_count_o),
        .halt_hit_o (halt_hit)
    );

    // Reset gates ready directly since the idle state is also the reset state.
    assign host_ready_o = (state_q == StIdle) && !run_req_i && !rst_i;
    assign cmd_o        = ((state_q == StIssue) || (state_q == StWait)) ? op_q : OpRegRd;
    assign addr_o       = addr_q;
    assign data_o       = wdata_q;
    assign rsp_valid_o  = (state_q == StResp);
    assign rsp_data_o   = rsp_data_q;
    assign core_reset_o = (state_q != StRun);
    assign running_o    = (state_q == StRun);

endmodule
